// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module : stage_sequencer
// Steps NSTAGES pipeline stages per instruction; tracks PC, retired count,
// boundary halts and per-stage timeout.   Rev 1.0
// ============================================================================
module stage_sequencer #(
  parameter int              NSTAGES  = 4,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              PC_STAGE = 2,
  parameter int              TIMEOUT  = 15,
  parameter int              CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NSTAGES-1:0]         stage_done_i,
  input  logic                       stall_i,
  input  logic                       halt_i,
  input  logic [PC_W-1:0]            next_pc_i,
  output logic [NSTAGES-1:0]         stage_en_o,
  output logic [NSTAGES-1:0]         stage_rstn_o,
  output logic [$clog2(NSTAGES)-1:0] stage_o,
  output logic [PC_W-1:0]            pc_o,
  output logic [CNT_W-1:0]           instret_o,
  output logic                       busy_o,
  output logic                       halted_o,
  output logic                       timeout_o
);
  localparam int                  c_STG_W  = $clog2(NSTAGES);
  localparam int                  c_WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_STG_W-1:0]  c_LAST   = c_STG_W'(NSTAGES - 1);
  localparam logic [c_STG_W-1:0]  c_PC_STG = c_STG_W'(PC_STAGE);
  localparam logic [c_WAIT_W-1:0] c_TMO    = c_WAIT_W'(TIMEOUT);

  // S_ENTRY is the reset mode: the next edge enters stage 0.
  typedef enum logic [1:0] {
    S_ENTRY = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2,
    S_ERR   = 2'd3
  } mode_t;

  mode_t               r_mode, w_mode_nxt;
  logic [c_STG_W-1:0]  r_stage, w_stage_nxt;
  logic [PC_W-1:0]     r_pc, w_pc_nxt;
  logic [CNT_W-1:0]    r_instret, w_instret_nxt;
  logic [c_WAIT_W-1:0] r_wait, w_wait_nxt;
  logic [NSTAGES-1:0]  r_en, w_en_nxt;
  logic [NSTAGES-1:0]  r_srst, w_srst_nxt;
  logic                r_busy, r_halted, r_timeout;
  logic                w_accept, w_wrap, w_expired;

  assign w_accept  = stage_done_i[r_stage];
  assign w_wrap    = (r_stage == c_LAST);
  assign w_expired = (TIMEOUT > 0) && (r_wait == c_TMO);

  always_comb begin
    w_mode_nxt    = r_mode;
    w_stage_nxt   = r_stage;
    w_pc_nxt      = r_pc;
    w_instret_nxt = r_instret;
    w_wait_nxt    = r_wait;
    w_en_nxt      = '0;
    w_srst_nxt    = r_srst;
    case (r_mode)
      S_ENTRY: begin
        w_mode_nxt  = S_RUN;
        w_stage_nxt = '0;
        w_wait_nxt  = '0;
        w_en_nxt    = NSTAGES'(1);
        w_srst_nxt  = NSTAGES'(1);
      end
      S_RUN: begin
        // Stall outranks both the timeout and a pending done.
        if (!stall_i) begin
          if (w_expired) begin
            w_mode_nxt = S_ERR;
            w_srst_nxt = '0;
          end else if (w_accept) begin
            w_stage_nxt = w_wrap ? '0 : r_stage + 1'b1;
            w_wait_nxt  = '0;
            if (r_stage == c_PC_STG) w_pc_nxt = next_pc_i;
            if (w_wrap) w_instret_nxt = r_instret + 1'b1;
            if (w_wrap && halt_i) begin
              w_mode_nxt = S_HALT;
              w_srst_nxt = '0;
            end else begin
              w_en_nxt   = NSTAGES'(1) << w_stage_nxt;
              w_srst_nxt = NSTAGES'(1) << w_stage_nxt;
            end
          end else if (TIMEOUT > 0) begin
            w_wait_nxt = r_wait + 1'b1;
          end
        end
      end
      S_HALT: begin
        if (!halt_i) begin
          w_mode_nxt  = S_RUN;
          w_stage_nxt = '0;
          w_wait_nxt  = '0;
          w_en_nxt    = NSTAGES'(1);
          w_srst_nxt  = NSTAGES'(1);
        end
      end
      default: begin
        w_srst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mode    <= S_ENTRY;
      r_stage   <= '0;
      r_pc      <= RESET_PC;
      r_instret <= '0;
      r_wait    <= '0;
      r_en      <= '0;
      r_srst    <= '0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_mode    <= w_mode_nxt;
      r_stage   <= w_stage_nxt;
      r_pc      <= w_pc_nxt;
      r_instret <= w_instret_nxt;
      r_wait    <= w_wait_nxt;
      r_en      <= w_en_nxt;
      r_srst    <= w_srst_nxt;
      r_busy    <= (w_mode_nxt == S_RUN);
      r_halted  <= (w_mode_nxt == S_HALT);
      r_timeout <= (w_mode_nxt == S_ERR);
    end
  end

  assign stage_en_o   = r_en;
  assign stage_rstn_o = r_srst;
  assign stage_o      = r_stage;
  assign pc_o         = r_pc;
  assign instret_o    = r_instret;
  assign busy_o       = r_busy;
  assign halted_o     = r_halted;
  assign timeout_o    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_stage_sequencer
// Directed bench for stage_sequencer: default, TIMEOUT=4 and 5-stage builds.
// Rev 1.0
// ============================================================================
module tb_stage_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default build
  logic        a_rstn, a_stall, a_halt;
  logic [3:0]  a_done, a_en, a_srst;
  logic [31:0] a_npc, a_pc, a_ir;
  logic [1:0]  a_stage;
  logic        a_busy, a_halted, a_to;

  // TIMEOUT=4 build
  logic        b_rstn, b_stall, b_halt;
  logic [3:0]  b_done, b_en, b_srst;
  logic [31:0] b_npc, b_pc, b_ir;
  logic [1:0]  b_stage;
  logic        b_busy, b_halted, b_to;

  // NSTAGES=5, PC_STAGE=4, CNT_W=3 build
  logic        d_rstn, d_stall, d_halt;
  logic [4:0]  d_done, d_en, d_srst;
  logic [31:0] d_npc, d_pc;
  logic [2:0]  d_ir, d_stage;
  logic        d_busy, d_halted, d_to;

  stage_sequencer u_dut_a (
    .clk(clk), .rstn(a_rstn), .stage_done_i(a_done), .stall_i(a_stall), .halt_i(a_halt),
    .next_pc_i(a_npc), .stage_en_o(a_en), .stage_rstn_o(a_srst), .stage_o(a_stage),
    .pc_o(a_pc), .instret_o(a_ir), .busy_o(a_busy), .halted_o(a_halted), .timeout_o(a_to)
  );

  stage_sequencer #(.TIMEOUT(4)) u_dut_b (
    .clk(clk), .rstn(b_rstn), .stage_done_i(b_done), .stall_i(b_stall), .halt_i(b_halt),
    .next_pc_i(b_npc), .stage_en_o(b_en), .stage_rstn_o(b_srst), .stage_o(b_stage),
    .pc_o(b_pc), .instret_o(b_ir), .busy_o(b_busy), .halted_o(b_halted), .timeout_o(b_to)
  );

  stage_sequencer #(.NSTAGES(5), .PC_STAGE(4), .CNT_W(3)) u_dut_d (
    .clk(clk), .rstn(d_rstn), .stage_done_i(d_done), .stall_i(d_stall), .halt_i(d_halt),
    .next_pc_i(d_npc), .stage_en_o(d_en), .stage_rstn_o(d_srst), .stage_o(d_stage),
    .pc_o(d_pc), .instret_o(d_ir), .busy_o(d_busy), .halted_o(d_halted), .timeout_o(d_to)
  );

  typedef struct packed {
    logic        rstn;
    logic [3:0]  done;
    logic        stall;
    logic        halt;
    logic [31:0] npc;
    logic [3:0]  en;
    logic [3:0]  srst;
    logic [1:0]  stage;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        busy;
    logic        halted;
    logic        to;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  function automatic vec_t v(input logic r, input logic [3:0] dn, input logic st, input logic hl,
                             input logic [31:0] np, input logic [3:0] en, input logic [3:0] sr,
                             input logic [1:0] sg, input logic [31:0] pc, input logic [31:0] ir,
                             input logic bz, input logic hd, input logic tm);
    vec_t t;
    t = '{r, dn, st, hl, np, en, sr, sg, pc, ir, bz, hd, tm};
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic b_edge(input logic r, input logic [3:0] dn, input logic st);
    b_rstn  = r;
    b_done  = dn;
    b_stall = st;
    @(posedge clk);
    #1;
  endtask

  // Reference model for the 5-stage build
  logic [2:0]  m_stage;
  logic [31:0] m_pc;
  logic [2:0]  m_ir;

  initial begin
    a_rstn = 0; a_done = 0; a_stall = 0; a_halt = 0; a_npc = 0;
    b_rstn = 0; b_done = 0; b_stall = 0; b_halt = 0; b_npc = 32'h100;
    d_rstn = 0; d_done = 0; d_stall = 0; d_halt = 0; d_npc = 0;

    //            rst done  stl hlt npc    en  srst stg pc  ir  bsy hlt to
    vecs[0]  = v(0, 4'h0, 0, 0, 0,    4'h0, 4'h0, 0, 0,  0, 0, 0, 0);
    vecs[1]  = v(0, 4'h0, 0, 0, 0,    4'h0, 4'h0, 0, 0,  0, 0, 0, 0);
    vecs[2]  = v(1, 4'h0, 0, 0, 0,    4'h1, 4'h1, 0, 0,  0, 1, 0, 0);
    vecs[3]  = v(1, 4'hF, 0, 0, 4,    4'h2, 4'h2, 1, 0,  0, 1, 0, 0);
    vecs[4]  = v(1, 4'hF, 0, 0, 4,    4'h4, 4'h4, 2, 0,  0, 1, 0, 0);
    vecs[5]  = v(1, 4'hF, 0, 0, 4,    4'h8, 4'h8, 3, 4,  0, 1, 0, 0);
    vecs[6]  = v(1, 4'hF, 0, 0, 8,    4'h1, 4'h1, 0, 4,  1, 1, 0, 0);
    vecs[7]  = v(1, 4'hF, 0, 0, 8,    4'h2, 4'h2, 1, 4,  1, 1, 0, 0);
    vecs[8]  = v(1, 4'hF, 0, 0, 8,    4'h4, 4'h4, 2, 4,  1, 1, 0, 0);
    vecs[9]  = v(1, 4'hF, 0, 0, 8,    4'h8, 4'h8, 3, 8,  1, 1, 0, 0);
    vecs[10] = v(1, 4'hF, 0, 0, 12,   4'h1, 4'h1, 0, 8,  2, 1, 0, 0);
    vecs[11] = v(1, 4'hF, 0, 0, 12,   4'h2, 4'h2, 1, 8,  2, 1, 0, 0);
    vecs[12] = v(1, 4'hF, 1, 0, 12,   4'h0, 4'h2, 1, 8,  2, 1, 0, 0);
    vecs[13] = v(1, 4'hF, 1, 0, 12,   4'h0, 4'h2, 1, 8,  2, 1, 0, 0);
    vecs[14] = v(1, 4'hF, 1, 0, 12,   4'h0, 4'h2, 1, 8,  2, 1, 0, 0);
    vecs[15] = v(1, 4'hF, 0, 0, 12,   4'h4, 4'h4, 2, 8,  2, 1, 0, 0);
    vecs[16] = v(1, 4'hF, 0, 1, 12,   4'h8, 4'h8, 3, 12, 2, 1, 0, 0);
    vecs[17] = v(1, 4'h0, 0, 1, 16,   4'h0, 4'h8, 3, 12, 2, 1, 0, 0);
    vecs[18] = v(1, 4'hF, 0, 1, 16,   4'h0, 4'h0, 0, 12, 3, 0, 1, 0);
    vecs[19] = v(1, 4'hF, 0, 1, 16,   4'h0, 4'h0, 0, 12, 3, 0, 1, 0);
    vecs[20] = v(1, 4'h0, 0, 0, 16,   4'h1, 4'h1, 0, 12, 3, 1, 0, 0);
    vecs[21] = v(1, 4'hF, 1, 0, 16,   4'h0, 4'h1, 0, 12, 3, 1, 0, 0);
    vecs[22] = v(1, 4'hF, 0, 0, 16,   4'h2, 4'h2, 1, 12, 3, 1, 0, 0);
    vecs[23] = v(1, 4'hF, 0, 0, 16,   4'h4, 4'h4, 2, 12, 3, 1, 0, 0);
    vecs[24] = v(0, 4'hF, 0, 0, 16,   4'h0, 4'h0, 0, 0,  0, 0, 0, 0);
    vecs[25] = v(1, 4'h0, 0, 0, 0,    4'h1, 4'h1, 0, 0,  0, 1, 0, 0);
    vecs[26] = v(1, 4'h0, 0, 0, 0,    4'h0, 4'h1, 0, 0,  0, 1, 0, 0);

    for (int i = 0; i < NV; i++) begin
      a_rstn  = vecs[i].rstn;
      a_done  = vecs[i].done;
      a_stall = vecs[i].stall;
      a_halt  = vecs[i].halt;
      a_npc   = vecs[i].npc;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {a_en, a_srst, a_stage, a_pc, a_ir, a_busy, a_halted, a_to},
            {vecs[i].en, vecs[i].srst, vecs[i].stage, vecs[i].pc, vecs[i].ir,
             vecs[i].busy, vecs[i].halted, vecs[i].to});
    end
    a_rstn = 0;

    // Timeout build: done on the 4th allowed cycle is accepted
    b_edge(0, 4'h0, 0);
    b_edge(1, 4'h0, 0);
    check("tmo_entry", {b_en, b_busy}, {4'h1, 1'b1});
    for (int k = 0; k < 3; k++) b_edge(1, 4'h0, 0);
    b_edge(1, 4'hF, 0);
    check("tmo_last_ok", {b_stage, b_en, b_busy, b_to}, {2'd1, 4'h2, 1'b1, 1'b0});
    // Stage 1 reaches the limit, then stalls: stall holds off ERR
    for (int k = 0; k < 4; k++) b_edge(1, 4'h0, 0);
    check("tmo_at_limit", {b_stage, b_busy, b_to}, {2'd1, 1'b1, 1'b0});
    for (int k = 0; k < 3; k++) b_edge(1, 4'h0, 1);
    check("tmo_stall_prio", {b_stage, b_srst, b_busy, b_to}, {2'd1, 4'h2, 1'b1, 1'b0});
    b_edge(1, 4'h0, 0);
    check("tmo_err_s1", {b_stage, b_en, b_srst, b_busy, b_to}, {2'd1, 4'h0, 4'h0, 1'b0, 1'b1});

    // Stage 0 never done: timeout in the 5th cycle after the start pulse
    b_edge(0, 4'h0, 0);
    check("tmo_reset", {b_srst, b_to, b_busy}, {4'h0, 1'b0, 1'b0});
    b_edge(1, 4'h0, 0);
    for (int k = 0; k < 4; k++) b_edge(1, 4'h0, 0);
    check("tmo_4th", {b_busy, b_to}, {1'b1, 1'b0});
    b_edge(1, 4'h0, 0);
    check("tmo_5th", {b_en, b_srst, b_stage, b_pc, b_busy, b_halted, b_to},
          {4'h0, 4'h0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1});
    for (int k = 0; k < 3; k++) b_edge(1, 4'hF, 0);
    check("tmo_sticky", {b_en, b_stage, b_ir, b_to}, {4'h0, 2'd0, 32'h0, 1'b1});
    b_edge(0, 4'h0, 0);
    check("tmo_clear", {b_to, b_busy, b_srst}, {1'b0, 1'b0, 4'h0});

    // 5-stage build: 9 instructions, PC and count share the wrap edge
    d_rstn = 1; d_done = 5'h1F;
    m_stage = 0; m_pc = 0; m_ir = 0;
    @(posedge clk);
    #1;
    check("d_entry", {d_stage, d_en, d_busy}, {3'd0, 5'h01, 1'b1});
    for (int k = 0; k < 45; k++) begin
      d_npc = m_pc + 32'd4;
      @(posedge clk);
      #1;
      if (m_stage == 3'd4) begin
        m_pc    = d_npc;
        m_ir    = m_ir + 3'd1;
        m_stage = 3'd0;
      end else begin
        m_stage = m_stage + 3'd1;
      end
      check($sformatf("d_step%0d", k), {d_stage, d_pc, d_ir, d_en},
            {m_stage, m_pc, m_ir, 5'(5'h01 << m_stage)});
    end
    check("d_final", {d_stage, d_pc, d_ir}, {3'd0, 32'd36, 3'd1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Parameter NSTAGES, default 4: number of sequenced stages, range 2..8.
REQ-002 Parameter PC_W, default 32: program-counter width.
REQ-003 Parameter RESET_PC, default 0: pc_o value after reset.
REQ-004 Parameter PC_STAGE, default 2: pc_o loads next_pc_i when this stage completes; range 0..NSTAGES-1.
REQ-005 Parameter TIMEOUT, default 15: non-stalled cycles allowed per stage; 0 disables the timeout.
REQ-006 Parameter CNT_W, default 32: instret_o width.
REQ-007 clk  in  1  clock; all state updates on the rising edge.
REQ-008 rstn  in  1  reset, synchronous, active-low.
REQ-009 stage_done_i  in  NSTAGES  level completion flag per stage; only bit stage_o is observed.
REQ-010 stall_i  in  1  freezes sequencing and the timeout count.
REQ-011 halt_i  in  1  halt request, honoured only at an instruction boundary.
REQ-012 next_pc_i  in  PC_W  next PC, sampled when stage PC_STAGE completes.
REQ-013 stage_en_o  out  NSTAGES  one-hot, one-cycle start pulse for the entered stage.
REQ-014 stage_rstn_o  out  NSTAGES  per-stage active-low reset; bit i is high only while stage i is current.
REQ-015 stage_o  out  clog2(NSTAGES)  current stage index.
REQ-016 pc_o  out  PC_W  current PC.
REQ-017 instret_o  out  CNT_W  retired-instruction count.
REQ-018 busy_o, halted_o, timeout_o  out  1 each  status flags; meanings per REQ-019.

Function
REQ-019 Modes: RUN, HALT, ERR; busy_o=1 only in RUN, halted_o=1 only in HALT, timeout_o=1 only in ERR; all outputs registered.
REQ-020 Stage entry occurs at the first non-reset edge and at every advance; in the following cycle stage_en_o=onehot(stage_o) and stage_en_o=0 in all other cycles.
REQ-021 Advance: an edge in RUN with stage_done_i[stage_o]=1 and stall_i=0 sets stage_o to (stage_o+1) mod NSTAGES.
REQ-022 Throughput: minimum 1 cycle per stage and NSTAGES cycles per instruction, with done accepted in the same cycle as its start pulse.
REQ-023 stall_i=1: no advance, done ignored, wait counter held; the stage must hold done until it is accepted.
REQ-024 stage_rstn_o = onehot(stage_o) in RUN, all-zero in HALT, ERR and reset; it updates on the same edge as stage_o.
REQ-025 pc_o <= next_pc_i on the advance out of stage PC_STAGE only.
REQ-026 Advance out of stage NSTAGES-1 (wrap) increments instret_o modulo 2^CNT_W.
REQ-027 If PC_STAGE = NSTAGES-1, the pc_o load and the instret_o increment occur on the same edge.
REQ-028 halt_i=1 at a wrap edge: stage_o=0, mode HALT, and no start pulse is issued.
REQ-029 halt_i at any non-wrap edge is ignored.
REQ-030 In HALT, the first edge with halt_i=0 returns to RUN and is a stage-0 entry.
REQ-031 Wait counter: cleared at entry, then incremented each non-stalled RUN cycle without an accepted done; the start-pulse cycle counts.
REQ-032 If TIMEOUT>0 and the counter reaches TIMEOUT without an accepted done, the next edge enters ERR; ERR is sticky until reset.
REQ-033 In ERR: stage_en_o=0, and stage_o, pc_o and instret_o are frozen.
REQ-034 Done on the final allowed cycle is accepted; it is an advance, not ERR.
REQ-035 stall_i=1 has priority over timeout; stall_i does not affect HALT or ERR.

Reset
REQ-036 rstn=0 at an edge forces: RUN mode pending entry, stage_o=0, pc_o=RESET_PC, instret_o=0, stage_en_o=0, stage_rstn_o=0, busy_o=0, halted_o=0, timeout_o=0.
REQ-037 Reset mid-stage, mid-stall, in HALT or in ERR aborts immediately with identical values.
REQ-038 After reset release, the first edge with rstn=1 is a stage-0 entry: start pulse bit 0, busy_o=1, stage_rstn_o=0001.

Verification
REQ-039 Defaults, done for each stage in its start-pulse cycle, next_pc_i=pc+4 -> one pulse per cycle 0,1,2,3,0...; pc_o 0->4->8 each 4 cycles; instret_o +1 per 4 cycles.
REQ-040 Stage 1 done asserted with stall_i=1 for 3 cycles -> stage_o stays 1 for those 3 cycles, advances on the first unstalled edge, and has no second pulse.
REQ-041 TIMEOUT=4, stage 0 never done -> timeout_o=1 in the 5th cycle after the start pulse; stage_en_o and stage_rstn_o = 0; pc_o=0; held until rstn=0.
REQ-042 halt_i=1 during stage 2 and wrap at instret 5 -> no halt at stage 2; HALT after the wrap with instret_o=6 and stage_o=0; halt_i=0 -> stage-0 pulse on the next cycle.
REQ-043 rstn=0 during stage 2 with pc_o=0x40 -> next cycle pc_o=0, instret_o=0, outputs 0; release -> stage-0 pulse.
REQ-044 NSTAGES=5, PC_STAGE=4, CNT_W=3, 9 instructions -> pc_o and instret_o update on the same edge; instret_o wraps 7->0 and reads 1.
